generic_bus_arbiter: RTL and testbench

//  Two-requester, one-target arbiter for the generic bus. m0 (instruction fetch) and m1 (data

---
 rtl/bus_arb_pkg.sv | 27 ++
 rtl/bus_watchdog.sv | 31 +++
 rtl/generic_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_generic_bus_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the two-requester generic bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic arb_sel_t;

    localparam arb_sel_t SEL_M0 = 1'b0;
    localparam arb_sel_t SEL_M1 = 1'b1;

    // Generic bus geometry for one word of a block.
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Grant state that serves the given requester.
    function automatic arb_state_t grant_state(input arb_sel_t sel);
        return (sel == SEL_M1) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts stalled grant cycles and flags expiry at TIMEOUT_CYCLES.
// Latency: expired is combinational from the registered count; count self-clears after expiry.
// Backpressure: none; incr is sampled every cycle, clear has priority over incr.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

    // Count stalled cycles; restart whenever the grant ends or the limit fires.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter sharing one downstream generic bus between fetch (m0) and data (m1); BUS_ARB_TIMEOUT_EN adds a watchdog.
// Latency: IDLE request reaches downstream next cycle; response returns combinationally; one IDLE bubble between transactions.
// Backpressure: requester holds its request while busy=1; downstream busy passes straight to the granted requester only.
module generic_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BLOCK_SIZE     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         CLK,
    input  logic                         nRST,
    // instruction-fetch requester
    input  logic [ADDR_W-1:0]            m0_addr,
    input  logic [WORD_W*BLOCK_SIZE-1:0] m0_wdata,
    input  logic [BE_W*BLOCK_SIZE-1:0]   m0_byte_en,
    input  logic                         m0_ren,
    input  logic                         m0_wen,
    output logic [WORD_W*BLOCK_SIZE-1:0] m0_rdata,
    output logic                         m0_busy,
    output logic                         m0_error,
    // data requester
    input  logic [ADDR_W-1:0]            m1_addr,
    input  logic [WORD_W*BLOCK_SIZE-1:0] m1_wdata,
    input  logic [BE_W*BLOCK_SIZE-1:0]   m1_byte_en,
    input  logic                         m1_ren,
    input  logic                         m1_wen,
    output logic [WORD_W*BLOCK_SIZE-1:0] m1_rdata,
    output logic                         m1_busy,
    output logic                         m1_error,
    // downstream memory port
    output logic [ADDR_W-1:0]            out_addr,
    output logic [WORD_W*BLOCK_SIZE-1:0] out_wdata,
    output logic [BE_W*BLOCK_SIZE-1:0]   out_byte_en,
    output logic                         out_ren,
    output logic                         out_wen,
    input  logic [WORD_W*BLOCK_SIZE-1:0] out_rdata,
    input  logic                         out_busy,
    input  logic                         out_error
);

    arb_state_t state;
    arb_sel_t   last_grant;
    arb_sel_t   sel;
    logic       granted;
    logic       req0;
    logic       req1;
    logic       req_sel;
    logic       expire;

    assign req0    = m0_ren | m0_wen;
    assign req1    = m1_ren | m1_wen;
    assign granted = (state == GRANT0) || (state == GRANT1);
    assign sel     = (state == GRANT1) ? SEL_M1 : SEL_M0;
    assign req_sel = (sel == SEL_M1) ? req1 : req0;

`ifdef BUS_ARB_TIMEOUT_EN
    logic wd_expired;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (!granted),
        .incr    (granted && out_busy),
        .expired (wd_expired)
    );

    assign expire = granted && wd_expired;
`else
    // Without the watchdog a hung target stalls the granted requester indefinitely.
    assign expire = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the grant until completion, drop, or watchdog expiry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= SEL_M1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        state <= grant_state(~last_grant);
                    end else if (req0) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (expire) begin
                        state      <= IDLE;
                        last_grant <= sel;
                    end else if (!req_sel) begin
                        // Abandoned request does not count as a turn.
                        state <= IDLE;
                    end else if (!out_busy) begin
                        state      <= IDLE;
                        last_grant <= sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Steer the granted requester downstream and return the response to it alone.
    always_comb begin
        out_addr    = '0;
        out_wdata   = '0;
        out_byte_en = '0;
        out_ren     = 1'b0;
        out_wen     = 1'b0;
        m0_busy     = 1'b1;
        m0_error    = 1'b0;
        m0_rdata    = '0;
        m1_busy     = 1'b1;
        m1_error    = 1'b0;
        m1_rdata    = '0;
        if (state == GRANT0) begin
            out_addr    = m0_addr;
            out_wdata   = m0_wdata;
            out_byte_en = m0_byte_en;
            out_ren     = m0_ren & ~expire;
            out_wen     = m0_wen & ~expire;
            m0_busy     = out_busy & ~expire;
            m0_error    = out_error | expire;
            m0_rdata    = expire ? '0 : out_rdata;
        end else if (state == GRANT1) begin
            out_addr    = m1_addr;
            out_wdata   = m1_wdata;
            out_byte_en = m1_byte_en;
            out_ren     = m1_ren & ~expire;
            out_wen     = m1_wen & ~expire;
            m1_busy     = out_busy & ~expire;
            m1_error    = out_error | expire;
            m1_rdata    = expire ? '0 : out_rdata;
        end
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Self-checking bench for generic_bus_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: the bench plays both requesters (hold until busy=0) and a random-latency target.
module tb_generic_bus_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_byte_en;
    logic        m0_ren, m0_wen, m0_busy, m0_error;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_byte_en;
    logic        m1_ren, m1_wen, m1_busy, m1_error;
    logic [31:0] out_addr, out_wdata, out_rdata;
    logic [3:0]  out_byte_en;
    logic        out_ren, out_wen, out_busy, out_error;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

    always #5 CLK = ~CLK;

    generic_bus_arbiter #(
        .BLOCK_SIZE     (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_byte_en (m0_byte_en),
        .m0_ren     (m0_ren),
        .m0_wen     (m0_wen),
        .m0_rdata   (m0_rdata),
        .m0_busy    (m0_busy),
        .m0_error   (m0_error),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_byte_en (m1_byte_en),
        .m1_ren     (m1_ren),
        .m1_wen     (m1_wen),
        .m1_rdata   (m1_rdata),
        .m1_busy    (m1_busy),
        .m1_error   (m1_error),
        .out_addr   (out_addr),
        .out_wdata  (out_wdata),
        .out_byte_en(out_byte_en),
        .out_ren    (out_ren),
        .out_wen    (out_wen),
        .out_rdata  (out_rdata),
        .out_busy   (out_busy),
        .out_error  (out_error)
    );

    function automatic logic busy_of(input int k);
        return (k == 1) ? m1_busy : m0_busy;
    endfunction

    function automatic logic error_of(input int k);
        return (k == 1) ? m1_error : m0_error;
    endfunction

    function automatic logic [31:0] rdata_of(input int k);
        return (k == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        m0_addr = '0; m0_wdata = '0; m0_byte_en = '0; m0_ren = 1'b0; m0_wen = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_byte_en = '0; m1_ren = 1'b0; m1_wen = 1'b0;
        out_rdata = '0; out_busy = 1'b0; out_error = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        m0_ren = 1'b1; m0_addr = 32'h4;
        m1_ren = 1'b1; m1_addr = 32'h8;
        out_busy = 1'b1;
        repeat (2) cyc();
        #1;
        vectors++; if (out_ren !== 1'b0) begin miscompares++; $display("FAIL reset_out_ren got %b want 0", out_ren); end
        vectors++; if (out_wen !== 1'b0) begin miscompares++; $display("FAIL reset_out_wen got %b want 0", out_wen); end
        vectors++; if (m0_busy !== 1'b1) begin miscompares++; $display("FAIL reset_m0_busy got %b want 1", m0_busy); end
        vectors++; if (m1_busy !== 1'b1) begin miscompares++; $display("FAIL reset_m1_busy got %b want 1", m1_busy); end
        nRST = 1'b1;
        cyc();
        #1;
        vectors++; if (out_ren !== 1'b1 || out_addr !== 32'h4) begin miscompares++; $display("FAIL reset_first_grant got ren=%b addr=%h want ren=1 addr=00000004", out_ren, out_addr); end
        vectors++; if (m1_busy !== 1'b1) begin miscompares++; $display("FAIL reset_m1_held got %b want 1", m1_busy); end
        out_busy = 1'b0;
        #1;
        vectors++; if (m0_busy !== 1'b0) begin miscompares++; $display("FAIL reset_m0_done got %b want 0", m0_busy); end
        cyc();
        m0_ren = 1'b0; m1_ren = 1'b0;
        cyc();
    endtask

    task automatic test_read();
        int   ren_cycles = 0;
        logic m1_ok      = 1'b1;
        idle_inputs();
        m0_ren = 1'b1; m0_addr = 32'h100; out_busy = 1'b1;
        #1;
        if (out_ren) ren_cycles++;
        if (m1_busy !== 1'b1) m1_ok = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 5) m0_ren = 1'b0;
            out_busy  = (i < 4);
            out_rdata = (i == 4) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (out_ren) ren_cycles++;
            if (m1_busy !== 1'b1) m1_ok = 1'b0;
            if (i < 4) begin
                vectors++; if (m0_busy !== 1'b1) begin miscompares++; $display("FAIL read_wait_%0d m0_busy got %b want 1", i, m0_busy); end
            end
            if (i == 4) begin
                vectors++; if (m0_busy !== 1'b0) begin miscompares++; $display("FAIL read_done_busy got %b want 0", m0_busy); end
                vectors++; if (m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rdata got %h want deadbeef", m0_rdata); end
                vectors++; if (out_addr !== 32'h100) begin miscompares++; $display("FAIL read_addr got %h want 00000100", out_addr); end
            end
        end
        vectors++; if (ren_cycles != 4) begin miscompares++; $display("FAIL read_ren_cycles got %0d want 4", ren_cycles); end
        vectors++; if (m1_ok !== 1'b1) begin miscompares++; $display("FAIL read_m1_busy got deasserted want held 1"); end
    endtask

    task automatic test_write_error();
        idle_inputs();
        m1_wen = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_byte_en = 4'b0011;
        out_busy = 1'b1;
        #1;
        cyc();
        #1;
        vectors++; if (out_wen !== 1'b1 || out_ren !== 1'b0) begin miscompares++; $display("FAIL wr_strobes got ren=%b wen=%b want 0/1", out_ren, out_wen); end
        vectors++; if (out_addr !== 32'h200) begin miscompares++; $display("FAIL wr_addr got %h want 00000200", out_addr); end
        vectors++; if (out_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_wdata got %h want 12345678", out_wdata); end
        vectors++; if (out_byte_en !== 4'b0011) begin miscompares++; $display("FAIL wr_byte_en got %b want 0011", out_byte_en); end
        cyc();
        out_busy = 1'b0; out_error = 1'b1;
        #1;
        vectors++; if (m1_busy !== 1'b0) begin miscompares++; $display("FAIL wr_done_busy got %b want 0", m1_busy); end
        vectors++; if (m1_error !== 1'b1) begin miscompares++; $display("FAIL wr_m1_error got %b want 1", m1_error); end
        vectors++; if (m0_error !== 1'b0) begin miscompares++; $display("FAIL wr_m0_error got %b want 0", m0_error); end
        cyc();
        m1_wen = 1'b0;
        #1;
        vectors++; if (m1_error !== 1'b0) begin miscompares++; $display("FAIL wr_error_latched got %b want 0", m1_error); end
        out_error = 1'b0;
        cyc();
    endtask

    task automatic test_round_robin();
        int next_win = 0;
        idle_inputs();
        m0_ren = 1'b1; m0_addr = 32'h10;
        m1_ren = 1'b1; m1_addr = 32'h20;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            #1;
            if (i % 2 == 0) begin
                vectors++; if ({out_ren, m0_busy, m1_busy} !== 3'b011) begin miscompares++; $display("FAIL rr_bubble_%0d got ren/b0/b1=%b want 011", i, {out_ren, m0_busy, m1_busy}); end
            end else begin
                vectors++; if (out_addr !== ((next_win == 1) ? 32'h20 : 32'h10)) begin miscompares++; $display("FAIL rr_addr_%0d got %h want m%0d", i, out_addr, next_win); end
                vectors++; if ({m0_busy, m1_busy} !== ((next_win == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_busy_%0d got %b want m%0d done", i, {m0_busy, m1_busy}, next_win); end
                next_win = 1 - next_win;
            end
        end
        cyc();
        m0_ren = 1'b0; m1_ren = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        idle_inputs();
        m0_ren = 1'b1; m0_addr = 32'h300; out_busy = 1'b1; out_rdata = 32'hFFFF_FFFF;
        #1;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (i == 1) begin m1_wen = 1'b1; m1_addr = 32'h400; end
            #1;
            if (i < 9) begin
                vectors++; if (m0_busy !== 1'b1) begin miscompares++; $display("FAIL wd_wait_%0d m0_busy got %b want 1", i, m0_busy); end
            end else begin
                vectors++; if (m0_busy !== 1'b0 || m0_error !== 1'b1) begin miscompares++; $display("FAIL wd_expire got busy=%b err=%b want 0/1", m0_busy, m0_error); end
                vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("FAIL wd_rdata got %h want 0", m0_rdata); end
                vectors++; if (out_ren !== 1'b0) begin miscompares++; $display("FAIL wd_out_ren got %b want 0", out_ren); end
            end
        end
        cyc();
        m0_ren = 1'b0;
        #1;
        vectors++; if ({out_ren, out_wen} !== 2'b00) begin miscompares++; $display("FAIL wd_bubble got %b want 00", {out_ren, out_wen}); end
        cyc();
        #1;
        vectors++; if (out_wen !== 1'b1 || out_addr !== 32'h400) begin miscompares++; $display("FAIL wd_next_grant got wen=%b addr=%h want 1/00000400", out_wen, out_addr); end
        out_busy = 1'b0;
        #1;
        vectors++; if (m1_busy !== 1'b0) begin miscompares++; $display("FAIL wd_m1_done got %b want 0", m1_busy); end
        cyc();
        m1_wen = 1'b0;
        cyc();
`else
        begin
            logic stuck_ok = 1'b1;
            for (int i = 1; i <= 120; i++) begin
                cyc();
                #1;
                if (m0_busy !== 1'b1 || out_ren !== 1'b1) stuck_ok = 1'b0;
            end
            vectors++; if (stuck_ok !== 1'b1) begin miscompares++; $display("FAIL hang_stall got released want busy=1 for 120 cycles"); end
            out_busy = 1'b0;
            #1;
            vectors++; if (m0_busy !== 1'b0) begin miscompares++; $display("FAIL hang_release got %b want 0", m0_busy); end
            cyc();
            m0_ren = 1'b0;
            cyc();
        end
`endif
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        m1_wen = 1'b1; m1_addr = 32'h500; m1_wdata = 32'hCAFE_0001; m1_byte_en = 4'hF;
        out_busy = 1'b1;
        #1;
        cyc();
        #1;
        vectors++; if (out_wen !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %b want 1", out_wen); end
        nRST = 1'b0;
        #1;
        vectors++; if (out_wen !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got %b want 0", out_wen); end
        vectors++; if (m1_busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy got %b want 1", m1_busy); end
        cyc();
        cyc();
        nRST = 1'b1;
        #1;
        vectors++; if (out_wen !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got %b want 0", out_wen); end
        cyc();
        #1;
        vectors++; if (out_wen !== 1'b1 || out_addr !== 32'h500) begin miscompares++; $display("FAIL rstmid_regrant got wen=%b addr=%h want 1/00000500", out_wen, out_addr); end
        out_busy = 1'b0;
        cyc();
        m1_wen = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic        p_act  [2];
        logic        p_wr   [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wdat [2];
        logic [3:0]  p_be   [2];
        int          gap    [2];
        logic        cur_req  [2];
        logic        prev_req [2];
        logic        prev_active = 1'b0;
        logic        prev_done   = 1'b0;
        logic        active, done, exp_active, exp_busy;
        logic        t_act = 1'b0;
        int          t_cnt = 0;
        int          owner = 0;
        int          last_win = 1;
        int          completions = 0;
        for (int k = 0; k < 2; k++) begin
            p_act[k] = 1'b0; p_wr[k] = 1'b0; p_addr[k] = '0; p_wdat[k] = '0; p_be[k] = '0;
            gap[k] = 0; prev_req[k] = 1'b0; cur_req[k] = 1'b0;
        end
        idle_inputs();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        cyc();
        for (int n = 0; n < 600; n++) begin
            m0_ren = p_act[0] & ~p_wr[0]; m0_wen = p_act[0] & p_wr[0];
            m0_addr = p_addr[0]; m0_wdata = p_wdat[0]; m0_byte_en = p_be[0];
            m1_ren = p_act[1] & ~p_wr[1]; m1_wen = p_act[1] & p_wr[1];
            m1_addr = p_addr[1]; m1_wdata = p_wdat[1]; m1_byte_en = p_be[1];
            for (int k = 0; k < 2; k++) cur_req[k] = p_act[k];
            #1;
            active     = out_ren | out_wen;
            exp_active = prev_active ? !prev_done : (prev_req[0] | prev_req[1]);
            vectors++; if (active !== exp_active) begin miscompares++; $display("FAIL rand_active cycle %0d got %b want %b", n, active, exp_active); end
            if (active && !t_act) begin
                owner = (prev_req[0] && prev_req[1]) ? (1 - last_win) : (prev_req[1] ? 1 : 0);
                t_act = 1'b1;
                t_cnt = $urandom_range(0, 3);
            end
            if (active) begin
                out_busy  = (t_cnt != 0);
                out_rdata = out_addr ^ RD_KEY;
                out_error = 1'b0;
                vectors++;
                if (out_addr !== p_addr[owner] || out_wen !== p_wr[owner] ||
                    (p_wr[owner] && (out_wdata !== p_wdat[owner] || out_byte_en !== p_be[owner]))) begin
                    miscompares++;
                    $display("FAIL rand_forward cycle %0d got addr=%h wen=%b want m%0d addr=%h wen=%b", n, out_addr, out_wen, owner, p_addr[owner], p_wr[owner]);
                end
            end else begin
                out_busy  = 1'($urandom_range(0, 1));
                out_rdata = $urandom;
                out_error = 1'($urandom_range(0, 1));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_busy = (active && k == owner) ? out_busy : 1'b1;
                vectors++; if (busy_of(k) !== exp_busy) begin miscompares++; $display("FAIL rand_busy_m%0d cycle %0d got %b want %b", k, n, busy_of(k), exp_busy); end
            end
            if (!active) begin
                vectors++; if ({m0_error, m1_error} !== 2'b00) begin miscompares++; $display("FAIL rand_idle_error cycle %0d got %b want 00", n, {m0_error, m1_error}); end
            end
            done = active && !out_busy;
            if (done) begin
                if (!p_wr[owner]) begin
                    vectors++; if (rdata_of(owner) !== (p_addr[owner] ^ RD_KEY)) begin miscompares++; $display("FAIL rand_rdata_m%0d got %h want %h", owner, rdata_of(owner), p_addr[owner] ^ RD_KEY); end
                end
                vectors++; if (error_of(owner) !== 1'b0) begin miscompares++; $display("FAIL rand_error_m%0d got %b want 0", owner, error_of(owner)); end
                last_win = owner;
                t_act = 1'b0;
                completions++;
                p_act[owner] = 1'b0;
                gap[owner] = $urandom_range(0, 2);
            end else if (active) begin
                t_cnt--;
            end
            for (int k = 0; k < 2; k++) begin
                if (!p_act[k]) begin
                    if (gap[k] > 0) begin
                        gap[k]--;
                    end else if ($urandom_range(0, 2) != 0) begin
                        p_act[k]  = 1'b1;
                        p_wr[k]   = 1'($urandom_range(0, 1));
                        p_addr[k] = {k[0], 31'($urandom)};
                        p_wdat[k] = $urandom;
                        p_be[k]   = 4'($urandom_range(1, 15));
                    end
                end
            end
            for (int k = 0; k < 2; k++) prev_req[k] = cur_req[k];
            prev_active = active;
            prev_done   = done;
            cyc();
        end
        vectors++; if (completions < 20) begin miscompares++; $display("FAIL rand_progress got %0d completions want at least 20", completions); end
        idle_inputs();
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish before 500us");
        $fatal(1, "bench timeout");
    end

    initial begin
        nRST = 1'b0;
        idle_inputs();
        test_reset();
        test_read();
        test_write_error();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
